// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing the single async_fifo write port among NUM_REQ valid/ready requesters.
// Optional packet lock (ASYNC_FIFO_ARB_PKT_LOCK_EN): the grant is held until a word with req_last is taken.
module async_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_en,
    input  logic                          full,
    input  logic                          overflow,
    input  logic                          clr_err,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          err_ovf
);

    // Handshake: a requester word moves when req_valid[i] & req_ready[i] are both high at a
    // rising wr_clk edge; that same condition is wr_en to the FIFO. A requester holds valid and
    // data stable until it sees ready.

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic                    err_ovf_q, err_ovf_d;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   sel_data;

`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
    logic                    lock_q, lock_d;
`else
    logic                    unused_req_last;
    assign unused_req_last = ^req_last;
`endif

    // First valid index after base, wrapping; base itself is the last candidate.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [ID_W-1:0]    base);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(base) + i) % NUM_REQ);
            if (!found && vld[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        xfer      = 1'b0;
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
        lock_d    = lock_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
                lock_d = 1'b0;
`endif
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, last_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_q] = ~full;
                wr_en              = req_valid[grant_q] & ~full;
                wr_data            = sel_data;
                xfer               = wr_en;
                if (xfer) begin
                    last_d = grant_q;
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
                    lock_d = ~req_last[grant_q];
                    if (req_last[grant_q]) begin
                        grant_d = rr_pick(req_valid, grant_q);
                    end
`else
                    // Searching from grant_q+1 visits grant_q last, so it only wins when alone.
                    grant_d = rr_pick(req_valid, grant_q);
`endif
                end else if (!req_valid[grant_q]) begin
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
                    if (!lock_q) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow set dominates a simultaneous clear.
    always_comb begin
        err_ovf_d = err_ovf_q;
        if (overflow) begin
            err_ovf_d = 1'b1;
        end else if (clr_err) begin
            err_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            err_ovf_q <= 1'b0;
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            err_ovf_q <= err_ovf_d;
`ifdef ASYNC_FIFO_ARB_PKT_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);
    assign err_ovf  = err_ovf_q;

endmodule

// File: doc/async_fifo_wr_arb.md
Name: async_fifo_wr_arb

Overview:
- Round-robin write-port arbiter for async_fifo in the wr_clk domain.
- Shares the single FIFO write port (wr_data/wr_en/full/overflow) among NUM_REQ requesters, each using a valid/ready handshake.
- Sequences grants with a small FSM and flags FIFO overflow events.
- Sits directly in front of the FIFO write side; the FIFO's own reset is driven separately.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- wr_clk  input  1  write-domain clock; all logic on posedge.
- wr_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  last word of packet (used only with the optional feature).
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- wr_data  output  DATA_WIDTH  to FIFO write data.
- wr_en  output  1  to FIFO write enable.
- full  input  1  from FIFO.
- overflow  input  1  from FIFO.
- clr_err  input  1  synchronous clear of err_ovf.
- grant_id  output  ID_W  currently granted requester.
- busy  output  1  FSM is in GRANT.
- err_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset: clock is wr_clk; reset is wr_rst_n, asynchronous assert, active-low.
  - On reset: state=IDLE, grant_q=0, last_q=NUM_REQ-1, err_ovf=0.
  - Outputs during reset: wr_en=0, req_ready=0, busy=0, grant_id=0, wr_data=0.
  - Reset mid-transfer aborts immediately; no partial write is issued.
- FSM states: IDLE, GRANT.
- IDLE:
  - wr_en=0, req_ready=0.
  - If any req_valid: round-robin pick p = first valid index searching last_q+1, last_q+2, ... modulo NUM_REQ.
  - Then grant_q<=p and move to GRANT next cycle. Arbitration costs one cycle.
- GRANT:
  - req_ready[grant_q] = ~full; all other ready bits 0.
  - wr_en = req_valid[grant_q] & ~full (combinational); wr_data = req_data slice of grant_q (combinational mux).
  - Transfer = wr_en. On a transfer: last_q<=grant_q.
  - Next grant after a transfer: re-arbitrate from pointer grant_q+1 over the current req_valid, excluding the data just taken.
    - If any requester is valid, grant_q<=pick and stay in GRANT; back-to-back transfers give 1 word/cycle with no bubble.
    - The picked requester may be grant_q itself if it is the only one valid.
    - If none is valid, go to IDLE.
  - full=1: no transfer; grant held; all ready=0.
  - req_valid[grant_q]=0 with no transfer: go to IDLE (re-arbitrate). last_q is unchanged.
- Requester rules:
  - Valid must stay high and data stable until ready.
  - The arbiter never drops or duplicates accepted words.
- grant_id = grant_q. busy = (state==GRANT).
- err_ovf:
  - Set on any cycle with overflow=1.
  - clr_err clears it; set wins over a simultaneous clear.
  - err_ovf never blocks arbitration.
- Fairness: with all requesters continuously valid and full=0, grants rotate 0,1,...,NUM_REQ-1 after the first IDLE pick, with one word each.
- Protocol guarantee: wr_en is never asserted while full=1.

Optional Feature:
- Macro: ASYNC_FIFO_ARB_PKT_LOCK_EN.
- Defined (packet lock):
  - After a transfer with req_last[grant_q]=0, grant_q is held and no re-arbitration occurs.
  - A transfer with req_last=1 releases the grant and triggers the normal re-arbitration.
  - Valid dropping mid-packet keeps the grant, and the FSM stays in GRANT.
  - Reset releases the lock.
- Not defined: req_last is ignored and each word is arbitrated independently. The port remains present and unused.

Test Plan:
- Single requester: req_valid=4'b0010 with data 8'hA5,8'hA6,8'hA7 and full=0 -> grant_id=1 one cycle after valid; wr_en high 3 consecutive cycles with wr_data A5,A6,A7; then IDLE with busy=0.
- All valid, full=0, 8 words: first grant 0 after reset -> write order 0,1,2,3,0,1,2,3 with no idle cycles between words.
- Backpressure: full=1 for 5 cycles while requester 2 is granted -> wr_en=0 and req_ready=0 throughout, grant_id stays 2; first write occurs in the cycle full falls, with the held data.
- Overflow flag: overflow pulse 1 cycle -> err_ovf=1 sticky; overflow and clr_err in the same cycle -> stays 1; clr_err alone -> 0 next cycle.
- Reset mid-burst: wr_rst_n low asynchronously during GRANT -> wr_en/req_ready/busy 0 immediately; after release, first grant goes to the lowest valid index.
- With ASYNC_FIFO_ARB_PKT_LOCK_EN: req0 sends a 3-word packet (last on word 3) while req1 is valid -> words 0,0,0 then 1. Without the macro, the same stimulus gives 0,1,0,1 interleaving.
